// File: rtl/bundler_hf_pkg.sv
// bundler_hf_pkg: shared helpers for the majority bundler; BUNDLER_HF_XOR_TIE_EN selects the XOR tie rule.
package bundler_hf_pkg;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
`ifdef BUNDLER_HF_XOR_TIE_EN
  localparam bit XOR_TIE = 1'b1;
`else
  localparam bit XOR_TIE = 1'b0;
`endif
endpackage

// File: rtl/bundler_hf_majority_bit.sv
// bundler_hf_majority_bit: popcount of one column and majority compare with tie input.
module bundler_hf_majority_bit import bundler_hf_pkg::*; #(
  parameter int NUM_HVS = 6
) (
  input  logic [NUM_HVS-1:0] col,
  input  logic               tie,
  output logic               maj
);
  localparam int W = cnt_width(NUM_HVS);
  localparam logic [W:0] NW = NUM_HVS[W:0];
  // Heap-indexed adder tree: leaves at NUM_HVS..2*NUM_HVS-1, root at 1.
  logic [W-1:0] s [1:2*NUM_HVS-1];
  logic [W:0] c2;
  genvar g;
  for (g = 0; g < NUM_HVS; g++) begin : g_leaf
    assign s[NUM_HVS+g] = W'(col[g]);
  end
  for (g = 1; g < NUM_HVS; g++) begin : g_node
    assign s[g] = s[2*g] + s[2*g+1];
  end
  assign c2 = {s[1], 1'b0};
  // For odd NUM_HVS the equality can never hold, so the tie term folds away.
  assign maj = (c2 > NW) | ((c2 == NW) & tie);
endmodule

// File: rtl/bundler_hf.sv
// bundler_hf: registered bitwise-majority bundler; BUNDLER_HF_XOR_TIE_EN selects the XOR tie rule.
module bundler_hf import bundler_hf_pkg::*; #(
  parameter int DIMENSIONS = 5,
  parameter int NUM_HVS    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIMENSIONS-1:0] hv_array [NUM_HVS-1:0],
  output logic                  out,
  output logic [DIMENSIONS-1:0] hv_out
);
  logic [DIMENSIONS-1:0] maj;
  genvar d, i;
  for (d = 0; d < DIMENSIONS; d++) begin : g_dim
    logic [NUM_HVS-1:0] col;
    logic tie;
    for (i = 0; i < NUM_HVS; i++) begin : g_col
      assign col[i] = hv_array[i][d];
    end
    assign tie = XOR_TIE ? hv_array[0][d] ^ hv_array[1][d] : hv_array[0][d];
    bundler_hf_majority_bit #(.NUM_HVS(NUM_HVS)) u_bit (.col(col), .tie(tie), .maj(maj[d]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= 1'b0;
      hv_out <= '0;
    end else begin
      out <= en;
      if (en) hv_out <= maj;
    end
  end
endmodule

// File: tb/tb_bundler_hf.sv
// tb_bundler_hf: directed and random checks of bundler_hf (NUM_HVS 6 and 5) against a counting model.
module tb_bundler_hf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [4:0] hv6 [5:0];
  logic [4:0] hv5 [4:0];
  logic out6, out5;
  logic [4:0] hv_out6, hv_out5;
  logic [4:0] exp6 = '0, exp5 = '0;
  logic exp_out = 1'b0;
  int checks = 0;
  int failures = 0;
`ifdef BUNDLER_HF_XOR_TIE_EN
  localparam bit XOR_MODE = 1'b1;
`else
  localparam bit XOR_MODE = 1'b0;
`endif

  always #5 clk = ~clk;

  bundler_hf #(.DIMENSIONS(5), .NUM_HVS(6)) dut (
    .clk(clk), .rst(rst), .en(en), .hv_array(hv6), .out(out6), .hv_out(hv_out6));
  bundler_hf #(.DIMENSIONS(5), .NUM_HVS(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .hv_array(hv5), .out(out5), .hv_out(hv_out5));

  function automatic logic [4:0] ref_maj(input logic [4:0] v [5:0], input int n);
    logic [4:0] r;
    for (int d = 0; d < 5; d++) begin
      int c = 0;
      for (int k = 0; k < n; k++) c += int'(v[k][d]);
      if (2 * c > n) r[d] = 1'b1;
      else if (2 * c < n) r[d] = 1'b0;
      else r[d] = XOR_MODE ? v[0][d] ^ v[1][d] : v[0][d];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic load(input logic [4:0] a, b, c, d, e, f);
    hv6[0] = a; hv6[1] = b; hv6[2] = c; hv6[3] = d; hv6[4] = e; hv6[5] = f;
    for (int k = 0; k < 5; k++) hv5[k] = hv6[k];
  endtask

  task automatic step(input logic e, input logic r);
    logic [4:0] v5 [5:0];
    @(negedge clk);
    en = e;
    rst = r;
    for (int k = 0; k < 6; k++) v5[k] = hv6[k];
    if (r) begin
      exp_out = 1'b0; exp6 = '0; exp5 = '0;
    end else begin
      exp_out = e;
      if (e) begin
        exp6 = ref_maj(hv6, 6);
        exp5 = ref_maj(v5, 5);
      end
    end
    @(posedge clk);
    #1;
    chk("out6", {4'b0, out6}, {4'b0, exp_out});
    chk("hv_out6", hv_out6, exp6);
    chk("out5", {4'b0, out5}, {4'b0, exp_out});
    chk("hv_out5", hv_out5, exp5);
  endtask

  initial begin
    load(5'b01101, 5'b00111, 5'b01111, 5'b10011, 5'b10011, 5'b11011);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("reset_lit", hv_out6, 5'b00000);
    step(1'b1, 1'b0);
    chk("set1_lit", hv_out6, XOR_MODE ? 5'b01011 : 5'b01111);
    chk("odd5_lit", hv_out5, 5'b00111);
    step(1'b0, 1'b0);
    load(5'b00010, 5'b10000, 5'b01000, 5'b10100, 5'b00100, 5'b10000);
    step(1'b1, 1'b0);
    chk("set2_lit", hv_out6, XOR_MODE ? 5'b10000 : 5'b00000);
    load(5'b11011, 5'b11011, 5'b01111, 5'b10111, 5'b11111, 5'b10000);
    step(1'b1, 1'b0);
    chk("set3_lit", hv_out6, 5'b11011);
    for (int c = 0; c < 9; c++) begin
      load(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      step(1'b0, 1'b0);
      chk("hold_lit", hv_out6, 5'b11011);
    end
    load(5'b01101, 5'b00111, 5'b01111, 5'b10011, 5'b10011, 5'b11011);
    step(1'b1, 1'b0);
    load(5'b00010, 5'b10000, 5'b01000, 5'b10100, 5'b00100, 5'b10000);
    step(1'b1, 1'b0);
    load(5'b11011, 5'b11011, 5'b01111, 5'b10111, 5'b11111, 5'b10000);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    for (int c = 0; c < 300; c++) begin
      load(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      step(1'($urandom), $urandom_range(0, 19) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
